// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs a hold-until-resp imem handshake,
// absorbs downstream stalls and EX redirects, and writes the IF/ID register.
module fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h6000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_address,
    output logic        imem_read,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic [6:0]  if_id_opcode,
    output logic [2:0]  if_id_funct3,
    output logic [6:0]  if_id_funct7
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DISCARD = 2'd1,
        HOLD    = 2'd2
    } state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    state_t      state_q, state_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] tgt_pc_q, tgt_pc_d;
    logic [31:0] buf_q, buf_d;
    if_id_t      if_id_q, if_id_d;

    logic [31:0] target;
    logic [31:0] req_next;

    assign target   = {redirect_pc_i[31:2], 2'b00};
    assign req_next = req_pc_q + 32'd4;

    assign imem_read    = (state_q == FETCH || state_q == DISCARD) && !rst;
    assign imem_address = req_pc_q;

    assign if_id_valid  = if_id_q.valid;
    assign if_id_pc     = if_id_q.pc;
    assign if_id_instr  = if_id_q.instr;
    assign if_id_opcode = if_id_q.instr[6:0];
    assign if_id_funct3 = if_id_q.instr[14:12];
    assign if_id_funct7 = if_id_q.instr[31:25];

    // Next-state: redirect beats stall, stall beats normal advance.
    always_comb begin
        state_d  = state_q;
        req_pc_d = req_pc_q;
        tgt_pc_d = tgt_pc_q;
        buf_d    = buf_q;
        if_id_d  = if_id_q;
        if (redirect_i) begin
            if_id_d.valid = 1'b0;
            unique case (state_q)
                FETCH: begin
                    if (imem_resp) begin
                        req_pc_d = target;
                    end else begin
                        tgt_pc_d = target;
                        state_d  = DISCARD;
                    end
                end
                DISCARD: begin
                    tgt_pc_d = target;
                    if (imem_resp) begin
                        req_pc_d = target;
                        state_d  = FETCH;
                    end
                end
                HOLD: begin
                    req_pc_d = target;
                    state_d  = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (imem_resp) begin
                        if (stall_i) begin
                            buf_d   = imem_rdata;
                            state_d = HOLD;
                        end else begin
                            if_id_d  = '{1'b1, req_pc_q, imem_rdata};
                            req_pc_d = req_next;
                        end
                    end else if (!stall_i) begin
                        if_id_d.valid = 1'b0;
                    end
                end
                DISCARD: begin
                    if (imem_resp) begin
                        req_pc_d = tgt_pc_q;
                        state_d  = FETCH;
                    end
                    if (!stall_i) begin
                        if_id_d.valid = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        if_id_d  = '{1'b1, req_pc_q, buf_q};
                        req_pc_d = req_next;
                        state_d  = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    // State, PC and IF/ID registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FETCH;
            req_pc_q <= PC_RESET;
            tgt_pc_q <= '0;
            buf_q    <= '0;
            if_id_q  <= '0;
        end else begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
            tgt_pc_q <= tgt_pc_d;
            buf_q    <= buf_d;
            if_id_q  <= if_id_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then
// random stall/redirect/latency/reset traffic checked against a fetch model.
module tb_fetch_stage;

    localparam logic [31:0] PC_RESET = 32'h6000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] imem_address;
    logic        imem_read;
    logic [31:0] imem_rdata = '0;
    logic        imem_resp = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic [6:0]  if_id_opcode;
    logic [2:0]  if_id_funct3;
    logic [6:0]  if_id_funct7;

    int n_pass = 0;
    int n_total = 0;
    bit cmp_en = 1'b0;

    fetch_stage #(.PC_RESET(PC_RESET)) dut (
        .clk(clk),
        .rst(rst),
        .imem_address(imem_address),
        .imem_read(imem_read),
        .imem_rdata(imem_rdata),
        .imem_resp(imem_resp),
        .stall_i(stall_i),
        .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .if_id_valid(if_id_valid),
        .if_id_pc(if_id_pc),
        .if_id_instr(if_id_instr),
        .if_id_opcode(if_id_opcode),
        .if_id_funct3(if_id_funct3),
        .if_id_funct7(if_id_funct7)
    );

    always #5 clk = ~clk;

    // Memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h00F0_5033;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t",
                      name, act, exp, $time);
    endtask

    // Reference model: the next address to fetch, whether the outstanding
    // request belongs to a squashed path (and where to go after it), an
    // optional parked instruction, and the IF/ID contents.
    logic [31:0] m_next = PC_RESET;
    bit          m_wrong = 1'b0;
    logic [31:0] m_tgt = '0;
    bit          m_held = 1'b0;
    logic [31:0] m_hword = '0;
    bit          m_v = 1'b0;
    logic [31:0] m_pc = '0;
    logic [31:0] m_instr = '0;
    logic [31:0] m_t;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_next = PC_RESET; m_wrong = 0; m_tgt = '0;
            m_held = 0; m_hword = '0;
            m_v = 0; m_pc = '0; m_instr = '0;
        end else begin
            m_t = redirect_pc_i & ~32'd3;
            if (redirect_i) begin
                m_v = 0;
                if (m_held) begin
                    m_held = 0;
                    m_next = m_t;
                end else if (m_wrong) begin
                    m_tgt = m_t;
                    if (imem_resp) begin m_wrong = 0; m_next = m_t; end
                end else if (imem_resp) begin
                    m_next = m_t;
                end else begin
                    m_wrong = 1; m_tgt = m_t;
                end
            end else if (m_held) begin
                if (!stall_i) begin
                    m_v = 1; m_pc = m_next; m_instr = m_hword;
                    m_held = 0; m_next = m_next + 4;
                end
            end else if (m_wrong) begin
                if (imem_resp) begin m_wrong = 0; m_next = m_tgt; end
                if (!stall_i) m_v = 0;
            end else if (imem_resp) begin
                if (stall_i) begin
                    m_held = 1; m_hword = word(m_next);
                end else begin
                    m_v = 1; m_pc = m_next; m_instr = word(m_next);
                    m_next = m_next + 4;
                end
            end else if (!stall_i) begin
                m_v = 0;
            end
        end
    end

    // Every cycle, compare DUT outputs with the model mid-cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            bit exp_rd;
            exp_rd = !rst && !m_held;
            chk("imem_read", 32'(imem_read), 32'(exp_rd));
            if (exp_rd) chk("imem_address", imem_address, m_next);
            chk("if_id_valid", 32'(if_id_valid), 32'(m_v));
            if (m_v) begin
                chk("if_id_pc", if_id_pc, m_pc);
                chk("if_id_instr", if_id_instr, m_instr);
                chk("if_id_opcode", 32'(if_id_opcode), 32'(m_instr[6:0]));
                chk("if_id_funct3", 32'(if_id_funct3), 32'(m_instr[14:12]));
                chk("if_id_funct7", 32'(if_id_funct7), 32'(m_instr[31:25]));
            end
        end
    end

    // Drive one cycle's inputs (just after the edge), then wait to the next.
    task automatic step(input bit r, input bit st, input bit rd,
                        input logic [31:0] rpc, input bit rsp);
        rst = r;
        #1;
        stall_i = st;
        redirect_i = rd;
        redirect_pc_i = rpc;
        imem_resp = rsp && imem_read;
        imem_rdata = imem_resp ? word(imem_address) : $urandom;
        @(posedge clk);
        #2;
    endtask

    task automatic see(input string name, input bit v,
                       input logic [31:0] pc, input bit rd,
                       input logic [31:0] addr);
        chk({name, " valid"}, 32'(if_id_valid), 32'(v));
        if (v) begin
            chk({name, " pc"}, if_id_pc, pc);
            chk({name, " instr"}, if_id_instr, word(pc));
        end
        chk({name, " read"}, 32'(imem_read), 32'(rd));
        if (rd) chk({name, " addr"}, imem_address, addr);
    endtask

    initial begin
        #1 rst = 1'b1;
        cmp_en = 1'b1;
        @(posedge clk);
        #2;
        chk("reset read", 32'(imem_read), 32'd0);
        chk("reset valid", 32'(if_id_valid), 32'd0);
        chk("reset pc", if_id_pc, 32'd0);
        chk("reset instr", if_id_instr, 32'd0);

        // Zero-wait memory: one instruction per cycle.
        step(0, 0, 0, 0, 1);
        see("zw0", 1, 32'h6000_0000, 1, 32'h6000_0004);
        step(0, 0, 0, 0, 1);
        see("zw1", 1, 32'h6000_0004, 1, 32'h6000_0008);
        step(0, 0, 0, 0, 1);
        see("zw2", 1, 32'h6000_0008, 1, 32'h6000_000C);

        // Three-cycle latency.
        step(0, 0, 0, 0, 0);
        see("lat0", 0, 0, 1, 32'h6000_000C);
        step(0, 0, 0, 0, 0);
        see("lat1", 0, 0, 1, 32'h6000_000C);
        step(0, 0, 0, 0, 1);
        see("lat2", 1, 32'h6000_000C, 1, 32'h6000_0010);

        // Response arrives under a 2-cycle stall.
        step(0, 1, 0, 0, 1);
        see("hold0", 1, 32'h6000_000C, 0, 0);
        step(0, 1, 0, 0, 1);
        see("hold1", 1, 32'h6000_000C, 0, 0);
        step(0, 0, 0, 0, 0);
        see("hold2", 1, 32'h6000_0010, 1, 32'h6000_0014);

        // Redirect while a request is outstanding.
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h6000_0100, 0);
        see("disc0", 0, 0, 1, 32'h6000_0014);
        step(0, 0, 0, 0, 0);
        see("disc1", 0, 0, 1, 32'h6000_0014);
        step(0, 0, 0, 0, 1);
        see("disc2", 0, 0, 1, 32'h6000_0100);
        step(0, 0, 0, 0, 1);
        see("disc3", 1, 32'h6000_0100, 1, 32'h6000_0104);

        // Redirect with resp and stall together; low target bits ignored.
        step(0, 1, 1, 32'h6000_0203, 1);
        see("rds0", 0, 0, 1, 32'h6000_0200);
        step(0, 0, 0, 0, 1);
        see("rds1", 1, 32'h6000_0200, 1, 32'h6000_0204);

        // PC wraps at the top of the address space.
        step(0, 0, 1, 32'hFFFF_FFFC, 1);
        step(0, 0, 0, 0, 1);
        see("wrap0", 1, 32'hFFFF_FFFC, 1, 32'h0000_0000);
        step(0, 0, 0, 0, 1);
        see("wrap1", 1, 32'h0000_0000, 1, 32'h0000_0004);

        // Reset mid-request.
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        chk("mid rst read", 32'(imem_read), 32'd0);
        chk("mid rst valid", 32'(if_id_valid), 32'd0);
        chk("mid rst pc", if_id_pc, 32'd0);
        chk("mid rst instr", if_id_instr, 32'd0);
        step(1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        see("post rst", 0, 0, 1, PC_RESET);

        // Random traffic against the model.
        repeat (3000) begin
            step(($urandom % 400) == 0, ($urandom % 10) < 3,
                 ($urandom % 16) == 0, $urandom, ($urandom % 2) == 0);
        end
        step(0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
